// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_EN.
package dmem_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Misaligned word access or any address bit above the storage range set
   function automatic logic access_err(input logic [31:0] addr, input int addr_w);
      logic [31:0] hi;
      hi = addr >> (addr_w + 2);
      return (addr[1:0] != 2'b00) || (hi != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous lane-enabled write, registered read port.
// Contents are never reset; only the read register is.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [3:0]        wr_be,
   input  logic              rd_en,
   input  logic              rd_zero,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = rd_zero ? '0 : mem_q[addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         for (int l = 0; l < 4; l++) begin
            if (wr_be[l]) begin
               mem_q[addr][l*8 +: 8] <= wdata[l*8 +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with WAIT_CYCLES wait states and a one-cycle ack pulse.
// Defining DMEM_BYTE_EN adds the 4-bit byte-enable port be.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_BYTE_EN
   input  logic [3:0]        be,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   output logic              err
);

   localparam logic [CNT_W-1:0] LAST_CNT =
      (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [3:0]        be_in;

   logic              cur_we;
   logic [31:0]       cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [3:0]        cur_be;
   logic              cur_err;
   logic              enter_resp;
   logic              wr_en;
   logic              rd_en;

`ifdef DMEM_BYTE_EN
   assign be_in = be;
`else
   assign be_in = 4'hF;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               be_d    = be_in;
               cnt_d   = '0;
               state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == LAST_CNT) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With zero wait states the access completes on the accept edge itself,
   // so the live inputs stand in for the not-yet-captured request regs.
   always_comb begin
      cur_we    = (state_q == IDLE) ? we    : we_q;
      cur_addr  = (state_q == IDLE) ? addr  : addr_q;
      cur_wdata = (state_q == IDLE) ? wdata : wdata_q;
      cur_be    = (state_q == IDLE) ? be_in : be_q;
      cur_err   = access_err(cur_addr, ADDR_W);
      enter_resp = (state_d == RESP) && (state_q != RESP);
      ack_d     = enter_resp;
      err_d     = enter_resp && cur_err;
      busy_d    = (state_d != IDLE);
      wr_en     = enter_resp && cur_we && !cur_err;
      rd_en     = enter_resp && (!cur_we || cur_err);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_be   (cur_be),
      .rd_en   (rd_en),
      .rd_zero (cur_err),
      .addr    (cur_addr[ADDR_W+1:2]),
      .wdata   (cur_wdata),
      .rdata   (rdata)
   );

   assign ack  = ack_q;
   assign err  = err_q;
   assign busy = busy_q;

endmodule
